// File: rtl/apb_master_if.sv
// ---------------------------------------------------------------------------
// apb_master_if
// Bundles the command/response handshake and the APB4 bus used by
// apb_master.
//   master modport : the view of apb_master itself (drives cmd_ready, rsp_*,
//                    and the APB request signals)
//   slave modport  : the view of the surrounding logic (command source,
//                    response sink and APB completer)
// Parameters:
//   AWIDTH : address width in bits
//   DSIZE  : log2 of the data width in bytes
// ---------------------------------------------------------------------------
interface apb_master_if #(
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned DSIZE  = 2
);
    localparam int unsigned DBYTES = 1 << DSIZE;
    localparam int unsigned DWIDTH = DBYTES * 8;

    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [2:0]        cmd_prot;
    logic [DBYTES-1:0] cmd_strb;
    logic [DWIDTH-1:0] cmd_wdata;

    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;

    // APB4 bus
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AWIDTH-1:0] paddr;
    logic [2:0]        pprot;
    logic [DBYTES-1:0] pstrb;
    logic [DWIDTH-1:0] pwdata;
    logic [DWIDTH-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_prot, cmd_strb, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pprot, pstrb, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_prot, cmd_strb, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pprot, pstrb, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB4 requester: turns a valid/ready command into a single APB transfer and
// returns the result on a valid/ready response channel. One transfer in
// flight; all APB outputs come straight from flops.
// Ports:
//   pclk    : clock
//   presetn : asynchronous active-low reset
//   bus     : apb_master_if.master (cmd_*, rsp_*, APB4 signals)
// Parameters:
//   AWIDTH : address width in bits
//   DSIZE  : log2 of the data width in bytes
//   TOUT   : ACCESS-phase timeout in cycles (1..255), timeout build only
// Optional feature:
//   APB_MASTER_TIMEOUT_EN : when defined, a transfer stuck in ACCESS for TOUT
//   cycles is aborted with rsp_err = 1. Undefined (default): ACCESS waits
//   for pready indefinitely.
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned DSIZE  = 2,
    parameter int unsigned TOUT   = 16
) (
    input  logic         pclk,
    input  logic         presetn,
    apb_master_if.master bus
);
    localparam int unsigned DBYTES = 1 << DSIZE;
    localparam int unsigned DWIDTH = DBYTES * 8;

    // The timeout counter is 8 bits wide, so TOUT must fit in 1..255.
    if (TOUT < 1 || TOUT > 255) begin : g_tout_range
        $error("apb_master: TOUT must be in the range 1..255");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic [2:0]        pprot_q, pprot_d;
    logic [DBYTES-1:0] pstrb_q, pstrb_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

    logic [7:0] tout_cnt_q, tout_cnt_d;

    // Counts ACCESS cycles without pready; cleared while in SETUP so it
    // starts from zero on entry to ACCESS.
    always_comb begin
        tout_cnt_d = tout_cnt_q;
        if (state_q == SETUP) begin
            tout_cnt_d = '0;
        end else if (state_q == ACCESS && !bus.pready) begin
            tout_cnt_d = tout_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tout_cnt_q <= '0;
        end else begin
            tout_cnt_q <= tout_cnt_d;
        end
    end

    // Abort in the cycle that would take the count to TOUT; pready in that
    // same cycle still completes normally.
    assign timeout = (state_q == ACCESS) && !bus.pready && (tout_cnt_q == TOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pstrb_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pprot_q     <= pprot_d;
            pstrb_q     <= pstrb_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.pready || timeout) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: every register holds unless the current state updates it.
    always_comb begin
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pprot_d     = pprot_q;
        pstrb_d     = pstrb_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = bus.cmd_write;
                    paddr_d   = bus.cmd_addr;
                    pprot_d   = bus.cmd_prot;
                    // Reads never present strobes or write data on the bus.
                    pstrb_d   = bus.cmd_write ? bus.cmd_strb  : '0;
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                end else if (timeout) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            RESP: begin
                if (bus.rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pprot     = pprot_q;
    assign bus.pstrb     = pstrb_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
